// File: rtl/branch_pkg.sv
// ============================================================================
// Module      : branch_pkg
// Description : Shared compare codes, branch op codes and FSM encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_pkg;

    localparam logic [1:0] BRANCH_DEFAULT = 2'b00;
    localparam logic [1:0] BRANCH_EQUAL   = 2'b01;
    localparam logic [1:0] BRANCH_LT      = 2'b10;
    localparam logic [1:0] BRANCH_GT      = 2'b11;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3;
    localparam logic [2:0] BR_BGE  = 3'd4;
    localparam logic [2:0] BR_BGT  = 3'd5;
    localparam logic [2:0] BR_BLE  = 3'd6;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/branch_resolve_cond.sv
// ============================================================================
// Module      : branch_cond
// Description : Maps (branch op, unsigned compare code) to a taken decision.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_cond
    import branch_pkg::*;
(
    input  logic [2:0] i_branch_op,
    input  logic [1:0] i_zero,
    output logic       o_take
);

    logic w_eq;
    logic w_lt;
    logic w_gt;

    assign w_eq = (i_zero == BRANCH_EQUAL);
    assign w_lt = (i_zero == BRANCH_LT);
    assign w_gt = (i_zero == BRANCH_GT);

    // A DEFAULT code leaves all three flags low, so every op resolves not-taken.
    always_comb begin
        o_take = 1'b0;
        case (i_branch_op)
            BR_BEQ:  o_take = w_eq;
            BR_BNE:  o_take = w_lt | w_gt;
            BR_BLT:  o_take = w_lt;
            BR_BGE:  o_take = w_eq | w_gt;
            BR_BGT:  o_take = w_gt;
            BR_BLE:  o_take = w_eq | w_lt;
            default: o_take = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/branch_resolve.sv
// ============================================================================
// Module      : branch_resolve
// Description : ID-stage branch resolution, registered PC redirect to IF and
//               branch/taken event counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve
    import branch_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_stall,
    input  logic [2:0]       branch_op,
    input  logic [1:0]       zero,
    input  logic [PC_W-1:0]  branch_target,
    input  logic             ex_flush,
    input  logic             redirect_ready,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             if_id_flush,
    output logic             br_stall,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    logic             w_take;
    logic             w_resolve;
    logic [0:0]       r_state_q;
    logic [0:0]       w_state_d;
    logic [PC_W-1:0]  r_pc_q;
    logic [PC_W-1:0]  w_pc_d;
    logic             r_flush_q;
    logic             w_flush_d;
    logic [CNT_W-1:0] r_branch_cnt_q;
    logic [CNT_W-1:0] w_branch_cnt_d;
    logic [CNT_W-1:0] r_taken_cnt_q;
    logic [CNT_W-1:0] w_taken_cnt_d;

    branch_cond u_cond (
        .i_branch_op (branch_op),
        .i_zero      (zero),
        .o_take      (w_take)
    );

    assign w_resolve = id_valid & (branch_op != BR_NONE) & ~id_stall
                     & (r_state_q == S_IDLE) & ~ex_flush;

    always_comb begin
        w_state_d      = r_state_q;
        w_pc_d         = r_pc_q;
        w_flush_d      = 1'b0;
        w_branch_cnt_d = r_branch_cnt_q;
        w_taken_cnt_d  = r_taken_cnt_q;
        if (ex_flush) begin
            w_state_d = S_IDLE;
        end else begin
            case (r_state_q)
                S_IDLE: begin
                    if (w_resolve) begin
                        w_branch_cnt_d = r_branch_cnt_q + CNT_W'(1);
                        if (w_take) begin
                            w_taken_cnt_d = r_taken_cnt_q + CNT_W'(1);
                            w_pc_d        = branch_target;
                            w_flush_d     = 1'b1;
                            w_state_d     = S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (redirect_ready) begin
                        w_state_d = S_IDLE;
                    end
                end
                default: w_state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= S_IDLE;
            r_pc_q         <= '0;
            r_flush_q      <= 1'b0;
            r_branch_cnt_q <= '0;
            r_taken_cnt_q  <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_pc_q         <= w_pc_d;
            r_flush_q      <= w_flush_d;
            r_branch_cnt_q <= w_branch_cnt_d;
            r_taken_cnt_q  <= w_taken_cnt_d;
        end
    end

    // The redirect is pending exactly while the FSM sits in ISSUE.
    assign redirect_valid = (r_state_q == S_ISSUE);
    assign br_stall       = (r_state_q == S_ISSUE);
    assign redirect_pc    = r_pc_q;
    assign if_id_flush    = r_flush_q;
    assign branch_cnt     = r_branch_cnt_q;
    assign taken_cnt      = r_taken_cnt_q;

endmodule

`default_nettype wire
